ctrl_word_skid: RTL and testbench
=================================

CTRL_WORD_SKID -- requirements
Module: ctrl_word_skid

Interface
REQ-001 Parameter WIDTH, default 26, SHALL set the decoded control-word width (one bit per decoder output).
REQ-002 Parameter OPW, default 7, SHALL set the width of the opcode tag carried alongside each control word.
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 in_valid  input  1  SHALL mean the upstream decoder presents a valid word.
REQ-006 in_ctrl  input  WIDTH  SHALL carry the decoded control word.
REQ-007 in_op  input  OPW  SHALL carry the opcode that produced in_ctrl.
REQ-008 in_ready  output  1  SHALL mean the block accepts a word this cycle.
REQ-009 out_valid  output  1  SHALL mean out_ctrl/out_op hold a valid word.
REQ-010 out_ctrl  output  WIDTH  SHALL carry the head control word.
REQ-011 out_op  output  OPW  SHALL carry the head opcode tag.
REQ-012 out_ready  input  1  SHALL mean downstream takes the head word this cycle.
REQ-013 occ  output  2  SHALL report the number of stored words (0..2).
REQ-014 clr_stall  input  1  SHALL synchronously clear stall_cnt.
REQ-015 stall_cnt  output  8  SHALL count cycles with out_valid=1 and out_ready=0.

Function
REQ-016 Accept SHALL occur when in_valid and in_ready are both 1; take SHALL occur when out_valid and out_ready are both 1.
REQ-017 Storage SHALL be a head register and a skid register; state SHALL be EMPTY (occ=0), ONE (occ=1) or FULL (occ=2).
REQ-018 in_ready SHALL be 1 in EMPTY and ONE and 0 in FULL, decoded from the state register only (no combinational path from out_ready).
REQ-019 out_valid SHALL be 1 in ONE and FULL, and out_ctrl/out_op SHALL always show the head register.
REQ-020 EMPTY: accept -> head<=input, ONE; no accept -> stay EMPTY.
REQ-021 ONE: accept and take -> head<=input, stay ONE; accept only -> skid<=input, FULL; take only -> EMPTY; neither -> hold.
REQ-022 FULL: take -> head<=skid, ONE; no take -> hold; accept cannot occur.
REQ-023 Latency from accept to out_valid SHALL be exactly 1 cycle when the block is EMPTY.
REQ-024 Words SHALL leave in acceptance order; no word SHALL be dropped or duplicated.
REQ-025 stall_cnt SHALL increment by 1 each stall cycle and saturate at 255.
REQ-026 clr_stall SHALL win over a simultaneous increment (next value 0).
REQ-027 In-flight data not yet taken SHALL be discarded when rst_n asserts mid-operation.

Reset
REQ-028 While rst_n=0: state EMPTY, occ=0, out_valid=0, out_ctrl=0, out_op=0, skid=0, stall_cnt=0.
REQ-029 in_ready SHALL read 1 during reset (state EMPTY); no accept SHALL take effect until the first rising edge after rst_n deasserts.

Configuration
REQ-030 With CTRL_SKID_PARITY_EN defined, an output out_par (1 bit) SHALL equal the even parity (XOR) of the head out_ctrl, computed at write time and stored with each word; its reset value is 0.
REQ-031 Without CTRL_SKID_PARITY_EN, out_par and its storage SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-032 Reset then in_valid=1, in_ctrl=26'h0000001, in_op=7'h05, out_ready=1 -> out_valid=1 next cycle with that word; occ=1.
REQ-033 out_ready=0, three back-to-back offers A=26'h1, B=26'h2, C=26'h3 -> A,B accepted, occ=2, in_ready=0 on C; raising out_ready yields A, B, C in order.
REQ-034 Hold FULL with out_ready=0 for 300 cycles -> stall_cnt reaches 255 and stays; clr_stall=1 for one cycle -> 0 on the next cycle.
REQ-035 Streaming in_valid=out_ready=1 for 100 words -> occ stays 1, one word per cycle, zero lost or duplicated.
REQ-036 rst_n pulsed low while FULL -> out_valid=0, occ=0, stall_cnt=0 immediately (asynchronous); old words never reappear.
REQ-037 CTRL_SKID_PARITY_EN defined, in_ctrl=26'h0000007 -> out_par=1; in_ctrl=26'h0000003 -> out_par=0.

Source files
------------

// File: rtl/ctrl_word_skid.sv
// ----------------------------------------------------------------------------
// ctrl_word_skid
//   Two-entry skid buffer (head + skid register) between an instruction
//   decoder and its consumer. Carries a decoded control word plus the opcode
//   tag that produced it. in_ready is decoded purely from the state register,
//   so there is no combinational path from out_ready back to the decoder.
//   Also counts stall cycles (out_valid=1, out_ready=0), saturating at 255.
//
// Parameters
//   WIDTH      decoded control-word width
//   OPW        opcode tag width
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   upstream word valid
//   in_ctrl    upstream control word
//   in_op      upstream opcode tag
//   in_ready   block accepts a word this cycle (state EMPTY or ONE)
//   out_valid  head word valid (state ONE or FULL)
//   out_ctrl   head control word
//   out_op     head opcode tag
//   out_ready  downstream takes the head word this cycle
//   occ        number of stored words (0..2)
//   clr_stall  synchronous clear of stall_cnt (wins over increment)
//   stall_cnt  saturating stall-cycle counter
//   out_par    (only with CTRL_SKID_PARITY_EN) XOR parity of the head word
//
// Optional feature macro: CTRL_SKID_PARITY_EN
// ----------------------------------------------------------------------------
module ctrl_word_skid #(
    parameter int unsigned WIDTH = 26,
    parameter int unsigned OPW   = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_ctrl,
    input  logic [OPW-1:0]   in_op,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_ctrl,
    output logic [OPW-1:0]   out_op,
    input  logic             out_ready,
    output logic [1:0]       occ,
    input  logic             clr_stall,
    output logic [7:0]       stall_cnt
`ifdef CTRL_SKID_PARITY_EN
    ,
    output logic             out_par
`endif
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Encoding equals the occupancy so occ is a direct view of the state.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   head_ctrl_q, head_ctrl_d;
    logic [OPW-1:0]     head_op_q, head_op_d;
    logic [WIDTH-1:0]   skid_ctrl_q, skid_ctrl_d;
    logic [OPW-1:0]     skid_op_q, skid_op_d;
    logic [CNT_W-1:0]   stall_q, stall_d;
`ifdef CTRL_SKID_PARITY_EN
    logic               head_par_q, head_par_d;
    logic               skid_par_q, skid_par_d;
    logic               in_par_c;
`endif

    logic in_ready_c;
    logic out_valid_c;
    logic accept_c;
    logic take_c;

    // Handshake decode from the state register only.
    assign in_ready_c  = (state_q != ST_FULL);
    assign out_valid_c = (state_q != ST_EMPTY);
    assign accept_c    = in_valid & in_ready_c;
    assign take_c      = out_valid_c & out_ready;

`ifdef CTRL_SKID_PARITY_EN
    // Parity is computed once at write time and travels with the word.
    assign in_par_c = ^in_ctrl;
`endif

    // Next-state and datapath steering.
    always_comb begin
        state_d     = state_q;
        head_ctrl_d = head_ctrl_q;
        head_op_d   = head_op_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_op_d   = skid_op_q;
`ifdef CTRL_SKID_PARITY_EN
        head_par_d  = head_par_q;
        skid_par_d  = skid_par_q;
`endif
        unique case (state_q)
            ST_EMPTY: begin
                if (accept_c) begin
                    head_ctrl_d = in_ctrl;
                    head_op_d   = in_op;
`ifdef CTRL_SKID_PARITY_EN
                    head_par_d  = in_par_c;
`endif
                    state_d     = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept_c && take_c) begin
                    head_ctrl_d = in_ctrl;
                    head_op_d   = in_op;
`ifdef CTRL_SKID_PARITY_EN
                    head_par_d  = in_par_c;
`endif
                end else if (accept_c) begin
                    skid_ctrl_d = in_ctrl;
                    skid_op_d   = in_op;
`ifdef CTRL_SKID_PARITY_EN
                    skid_par_d  = in_par_c;
`endif
                    state_d     = ST_FULL;
                end else if (take_c) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so only a take can happen.
                if (take_c) begin
                    head_ctrl_d = skid_ctrl_q;
                    head_op_d   = skid_op_q;
`ifdef CTRL_SKID_PARITY_EN
                    head_par_d  = skid_par_q;
`endif
                    state_d     = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Stall counter: clear has priority, otherwise saturating increment.
    always_comb begin
        stall_d = stall_q;
        if (clr_stall) begin
            stall_d = '0;
        end else if (out_valid_c && !out_ready && (stall_q != CNT_MAX)) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    // State and storage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            head_ctrl_q <= '0;
            head_op_q   <= '0;
            skid_ctrl_q <= '0;
            skid_op_q   <= '0;
            stall_q     <= '0;
`ifdef CTRL_SKID_PARITY_EN
            head_par_q  <= 1'b0;
            skid_par_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            head_ctrl_q <= head_ctrl_d;
            head_op_q   <= head_op_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_op_q   <= skid_op_d;
            stall_q     <= stall_d;
`ifdef CTRL_SKID_PARITY_EN
            head_par_q  <= head_par_d;
            skid_par_q  <= skid_par_d;
`endif
        end
    end

    assign in_ready  = in_ready_c;
    assign out_valid = out_valid_c;
    assign out_ctrl  = head_ctrl_q;
    assign out_op    = head_op_q;
    assign occ       = 2'(state_q);
    assign stall_cnt = stall_q;
`ifdef CTRL_SKID_PARITY_EN
    assign out_par   = head_par_q;
`endif

endmodule

// File: tb/tb_ctrl_word_skid.sv
// ----------------------------------------------------------------------------
// tb_ctrl_word_skid
//   Self-checking bench for ctrl_word_skid. Inputs change on the falling edge;
//   outputs are sampled 1 time unit later. Every accepted word is pushed to a
//   scoreboard queue and popped/compared when the DUT hands it downstream.
// ----------------------------------------------------------------------------
module tb_ctrl_word_skid;

    localparam int unsigned W  = 26;
    localparam int unsigned OW = 7;

    typedef struct packed {
        logic [W-1:0]  c;
        logic [OW-1:0] o;
    } item_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [W-1:0]  in_ctrl;
    logic [OW-1:0] in_op;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  out_ctrl;
    logic [OW-1:0] out_op;
    logic          out_ready;
    logic [1:0]    occ;
    logic          clr_stall;
    logic [7:0]    stall_cnt;
`ifdef CTRL_SKID_PARITY_EN
    logic          out_par;
`endif

    item_t sb[$];
    item_t exp_item;
    int    vectors     = 0;
    int    miscompares = 0;

    always #5 clk = ~clk;

    ctrl_word_skid #(.WIDTH(W), .OPW(OW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ctrl   (in_ctrl),
        .in_op     (in_op),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ctrl  (out_ctrl),
        .out_op    (out_op),
        .out_ready (out_ready),
        .occ       (occ),
        .clr_stall (clr_stall),
        .stall_cnt (stall_cnt)
`ifdef CTRL_SKID_PARITY_EN
        ,
        .out_par   (out_par)
`endif
    );

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = '1;
        in_op     = '1;
        out_ready = 1'b1;
        clr_stall = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        vectors++;
        if (occ !== 2'd0) begin miscompares++; $display("FAIL reset_occ got %0d want 0", occ); end
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        vectors++;
        if (out_ctrl !== '0) begin miscompares++; $display("FAIL reset_out_ctrl got %h want 0", out_ctrl); end
        vectors++;
        if (out_op !== '0) begin miscompares++; $display("FAIL reset_out_op got %h want 0", out_op); end
        vectors++;
        if (stall_cnt !== 8'd0) begin miscompares++; $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt); end
`ifdef CTRL_SKID_PARITY_EN
        vectors++;
        if (out_par !== 1'b0) begin miscompares++; $display("FAIL reset_out_par got %0b want 0", out_par); end
`endif
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL post_reset_out_valid got %0b want 0", out_valid); end
    endtask

    task automatic test_first_word();
        @(negedge clk);
        in_valid  = 1'b1;
        in_ctrl   = 26'h0000001;
        in_op     = 7'h05;
        out_ready = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL first_pre_valid got %0b want 0", out_valid); end
        if (in_valid && in_ready) sb.push_back('{c: in_ctrl, o: in_op});
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b1) begin miscompares++; $display("FAIL first_latency out_valid got %0b want 1", out_valid); end
        vectors++;
        if (occ !== 2'd1) begin miscompares++; $display("FAIL first_occ got %0d want 1", occ); end
        if (out_valid && out_ready) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++; $display("FAIL first_sb unexpected word %h", out_ctrl);
            end else begin
                exp_item = sb.pop_front();
                if (out_ctrl !== exp_item.c || out_op !== exp_item.o) begin
                    miscompares++; $display("FAIL first_data got %h/%h want %h/%h", out_ctrl, out_op, exp_item.c, exp_item.o);
                end
            end
        end
        @(negedge clk);
        #1;
        vectors++;
        if (occ !== 2'd0) begin miscompares++; $display("FAIL first_drain_occ got %0d want 0", occ); end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] words [3];
        bit c_done = 1'b0;
        int taken  = 0;
        words[0] = 26'h1; words[1] = 26'h2; words[2] = 26'h3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_ctrl   = words[i];
            in_op     = OW'(i + 16);
            #1;
            vectors++;
            if (occ !== 2'(i)) begin miscompares++; $display("FAIL bp_occ[%0d] got %0d want %0d", i, occ, i); end
            vectors++;
            if (in_ready !== (i < 2)) begin miscompares++; $display("FAIL bp_in_ready[%0d] got %0b want %0b", i, in_ready, (i < 2)); end
            if (in_valid && in_ready) begin
                sb.push_back('{c: in_ctrl, o: in_op});
                if (i == 2) c_done = 1'b1;
            end
        end
        // Raise out_ready; C keeps being offered until it gets in.
        for (int cyc = 0; cyc < 10 && !(c_done && sb.size() == 0); cyc++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = !c_done;
            #1;
            if (in_valid && in_ready) begin
                sb.push_back('{c: in_ctrl, o: in_op});
                c_done = 1'b1;
            end
            if (out_valid && out_ready) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++; $display("FAIL bp_sb unexpected word %h", out_ctrl);
                end else begin
                    exp_item = sb.pop_front();
                    taken++;
                    if (out_ctrl !== exp_item.c || out_op !== exp_item.o) begin
                        miscompares++; $display("FAIL bp_order got %h/%h want %h/%h", out_ctrl, out_op, exp_item.c, exp_item.o);
                    end
                end
            end
        end
        vectors++;
        if (taken != 3) begin miscompares++; $display("FAIL bp_count got %0d want 3", taken); end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        vectors++;
        if (occ !== 2'd0) begin miscompares++; $display("FAIL bp_final_occ got %0d want 0", occ); end
    endtask

    task automatic test_stall_sat();
        int exp_cnt;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_ctrl   = W'($urandom);
            in_op     = OW'($urandom);
            #1;
            if (in_valid && in_ready) sb.push_back('{c: in_ctrl, o: in_op});
        end
        @(negedge clk);
        in_valid  = 1'b0;
        clr_stall = 1'b1;
        #1;
        vectors++;
        if (occ !== 2'd2) begin miscompares++; $display("FAIL stall_fill_occ got %0d want 2", occ); end
        @(negedge clk);
        clr_stall = 1'b0;
        #1;
        vectors++;
        if (stall_cnt !== 8'd0) begin miscompares++; $display("FAIL stall_clr_wins got %0d want 0", stall_cnt); end
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            #1;
            exp_cnt = (k > 255) ? 255 : k;
            vectors++;
            if (stall_cnt !== 8'(exp_cnt)) begin
                miscompares++; $display("FAIL stall_cnt[%0d] got %0d want %0d", k, stall_cnt, exp_cnt);
            end
        end
        vectors++;
        if (occ !== 2'd2 || out_valid !== 1'b1) begin
            miscompares++; $display("FAIL stall_hold occ=%0d out_valid=%0b want 2/1", occ, out_valid);
        end
        @(negedge clk);
        clr_stall = 1'b1;
        @(negedge clk);
        clr_stall = 1'b0;
        out_ready = 1'b1;
        #1;
        vectors++;
        if (stall_cnt !== 8'd0) begin miscompares++; $display("FAIL stall_clear got %0d want 0", stall_cnt); end
        for (int cyc = 0; cyc < 6 && sb.size() != 0; cyc++) begin
            if (cyc != 0) begin
                @(negedge clk);
                #1;
            end
            if (out_valid && out_ready) begin
                vectors++;
                exp_item = sb.pop_front();
                if (out_ctrl !== exp_item.c || out_op !== exp_item.o) begin
                    miscompares++; $display("FAIL stall_drain got %h/%h want %h/%h", out_ctrl, out_op, exp_item.c, exp_item.o);
                end
            end
        end
        vectors++;
        if (sb.size() != 0) begin miscompares++; $display("FAIL stall_drain_left got %0d want 0", sb.size()); end
    endtask

    task automatic test_stream();
        int taken = 0;
        @(negedge clk);
        #1;
        vectors++;
        if (occ !== 2'd0) begin miscompares++; $display("FAIL stream_start_occ got %0d want 0", occ); end
        for (int i = 0; i <= 100; i++) begin
            @(negedge clk);
            in_valid  = (i < 100);
            in_ctrl   = W'($urandom);
            in_op     = OW'($urandom);
            out_ready = 1'b1;
            #1;
            if (i > 0) begin
                vectors++;
                if (occ !== 2'd1 || out_valid !== 1'b1) begin
                    miscompares++; $display("FAIL stream_occ[%0d] got occ=%0d valid=%0b want 1/1", i, occ, out_valid);
                end
            end
            if (in_valid && in_ready) sb.push_back('{c: in_ctrl, o: in_op});
            if (out_valid && out_ready) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++; $display("FAIL stream_sb unexpected word %h", out_ctrl);
                end else begin
                    exp_item = sb.pop_front();
                    taken++;
                    if (out_ctrl !== exp_item.c || out_op !== exp_item.o) begin
                        miscompares++; $display("FAIL stream_data[%0d] got %h/%h want %h/%h", i, out_ctrl, out_op, exp_item.c, exp_item.o);
                    end
                end
            end
        end
        vectors++;
        if (taken != 100 || sb.size() != 0) begin
            miscompares++; $display("FAIL stream_count got %0d taken %0d left want 100/0", taken, sb.size());
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        vectors++;
        if (occ !== 2'd0) begin miscompares++; $display("FAIL stream_end_occ got %0d want 0", occ); end
    endtask

    task automatic test_reset_midflight();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_ctrl   = 26'h2AA0000 | W'(i);
            in_op     = 7'h40;
            #1;
            if (in_valid && in_ready) sb.push_back('{c: in_ctrl, o: in_op});
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        vectors++;
        if (occ !== 2'd2) begin miscompares++; $display("FAIL rst_mid_fill_occ got %0d want 2", occ); end
        // Assert reset between clock edges to expose the asynchronous path.
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mid_out_valid got %0b want 0", out_valid); end
        vectors++;
        if (occ !== 2'd0) begin miscompares++; $display("FAIL rst_mid_occ got %0d want 0", occ); end
        vectors++;
        if (stall_cnt !== 8'd0) begin miscompares++; $display("FAIL rst_mid_stall got %0d want 0", stall_cnt); end
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_mid_in_ready got %0b want 1", in_ready); end
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++; $display("FAIL rst_mid_ghost[%0d] got valid=%0b ctrl=%h want 0", i, out_valid, out_ctrl);
            end
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_ctrl  = 26'h155AA55;
        in_op    = 7'h2A;
        #1;
        if (in_valid && in_ready) sb.push_back('{c: in_ctrl, o: in_op});
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b1) begin miscompares++; $display("FAIL rst_mid_new_valid got %0b want 1", out_valid); end
        if (out_valid && out_ready) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++; $display("FAIL rst_mid_sb unexpected word %h", out_ctrl);
            end else begin
                exp_item = sb.pop_front();
                if (out_ctrl !== exp_item.c || out_op !== exp_item.o) begin
                    miscompares++; $display("FAIL rst_mid_new_data got %h/%h want %h/%h", out_ctrl, out_op, exp_item.c, exp_item.o);
                end
            end
        end
        @(negedge clk);
    endtask

`ifdef CTRL_SKID_PARITY_EN
    task automatic test_parity();
        logic [W-1:0] words [2];
        words[0] = 26'h0000007;
        words[1] = 26'h0000003;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_ctrl   = words[i];
            in_op     = 7'h11;
            #1;
            if (in_valid && in_ready) sb.push_back('{c: in_ctrl, o: in_op});
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        vectors++;
        if (out_par !== 1'b1) begin miscompares++; $display("FAIL parity_7 got %0b want 1", out_par); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            out_ready = 1'b1;
            #1;
            if (i == 1) begin
                vectors++;
                if (out_par !== 1'b0) begin miscompares++; $display("FAIL parity_3 got %0b want 0", out_par); end
            end
            if (out_valid && out_ready) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++; $display("FAIL parity_sb unexpected word %h", out_ctrl);
                end else begin
                    exp_item = sb.pop_front();
                    if (out_ctrl !== exp_item.c || out_op !== exp_item.o) begin
                        miscompares++; $display("FAIL parity_data got %h/%h want %h/%h", out_ctrl, out_op, exp_item.c, exp_item.o);
                    end
                end
            end
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_first_word();
        test_backpressure();
        test_stall_sat();
        test_stream();
        test_reset_midflight();
`ifdef CTRL_SKID_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
